// File: rtl/lpf_mac_sched_pkg.sv
// ============================================================================
// Module      : lpf_pkg
// Description : Shared constants, tap coefficients and scheduler state
//               encoding for the time-multiplexed low-pass filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lpf_pkg;

    localparam int LPF_NTAPS = 72;
    localparam int LPF_TAP_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WRAP = 2'd2
    } lpf_sched_state_t;

    // Symmetric boxcar-style kernel; taps 0..70 sum to 883 (< 1024), so a
    // 10-bit guard on the accumulator can never overflow.
    localparam logic [LPF_TAP_W-1:0] LPF_COEF [0:LPF_NTAPS-1] = '{
        8'h51,
        8'h07, 8'h08, 8'h08, 8'h08, 8'h08, 8'h09, 8'h09, 8'h09, 8'h09,
        8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0B, 8'h0B, 8'h0B, 8'h0B, 8'h0C,
        8'h0C, 8'h0C, 8'h0D, 8'h0D, 8'h0D, 8'h0D, 8'h0E, 8'h0E, 8'h0E,
        8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E,
        8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E,
        8'h0E, 8'h0E, 8'h0E, 8'h0D, 8'h0D, 8'h0D, 8'h0D, 8'h0C, 8'h0C,
        8'h0C, 8'h0B, 8'h0B, 8'h0B, 8'h0B, 8'h0A, 8'h0A, 8'h0A, 8'h0A,
        8'h09, 8'h09, 8'h09, 8'h09, 8'h08, 8'h08, 8'h08, 8'h08, 8'h07,
        8'h51
    };

    function automatic logic [LPF_TAP_W-1:0] lpf_coef(input logic [6:0] idx);
        return (idx < 7'(LPF_NTAPS)) ? LPF_COEF[idx] : '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lpf_mac_sched_if.sv
// ============================================================================
// Module      : lpf_mac_sched_if
// Description : Sample/control bundle of the shared-MAC filter scheduler.
//               OVR/OVR_CLR exist only when LPF_SCHED_OVR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lpf_mac_sched_if #(
    parameter int MSB = 15,
    parameter int NCH = 2
);
    logic                     CE;
    logic                     ENABLE;
    logic [NCH*(MSB+1)-1:0]   IDATA;
    logic [NCH*(MSB+1)-1:0]   ODATA;
    logic                     OVALID;
    logic                     BUSY;
`ifdef LPF_SCHED_OVR_EN
    logic                     OVR;
    logic                     OVR_CLR;

    modport master (output CE, ENABLE, IDATA, OVR_CLR,
                    input  ODATA, OVALID, BUSY, OVR);
    modport slave  (input  CE, ENABLE, IDATA, OVR_CLR,
                    output ODATA, OVALID, BUSY, OVR);
`else
    modport master (output CE, ENABLE, IDATA,
                    input  ODATA, OVALID, BUSY);
    modport slave  (input  CE, ENABLE, IDATA,
                    output ODATA, OVALID, BUSY);
`endif
endinterface

`default_nettype wire

// File: rtl/lpf_mac_sched_tap_rom.sv
// ============================================================================
// Module      : lpf_tap_rom
// Description : Combinational 72x8 tap coefficient lookup shared by all
//               channels of the filter scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lpf_tap_rom
    import lpf_pkg::*;
(
    input  wire logic [6:0]           i_tap,
    output logic      [LPF_TAP_W-1:0] o_coef
);

    always_comb begin
        o_coef = lpf_coef(i_tap);
    end

endmodule

`default_nettype wire

// File: rtl/lpf_mac_sched.sv
// ============================================================================
// Module      : lpf_mac_sched
// Description : One tap ROM + one MAC time-shared across NCH channels; each
//               CE steps every channel through the current tap.
//               Optional sticky overrun flag: LPF_SCHED_OVR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lpf_mac_sched
    import lpf_pkg::*;
#(
    parameter int MSB = 15,
    parameter int NCH = 2
)(
    input wire logic        CLK,
    input wire logic        RESET,
    lpf_mac_sched_if.slave  bus
);

    localparam int c_sw = MSB + 1;
    localparam int c_pw = MSB + 9;
    localparam int c_aw = MSB + 11;
    localparam int c_cw = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0]      c_st_idle  = IDLE;
    localparam logic [1:0]      c_st_mac   = MAC;
    localparam logic [1:0]      c_st_wrap  = WRAP;
    localparam logic [c_cw-1:0] c_last_ch  = c_cw'(NCH - 1);
    localparam logic [6:0]      c_last_tap = 7'(LPF_NTAPS - 1);

    logic [1:0]           r_state;
    logic [6:0]           r_tap;
    logic [c_cw-1:0]      r_ch;
    logic                 r_ovalid;
    logic [c_sw-1:0]      r_smp [NCH];
    logic [c_aw-1:0]      r_acc [NCH];
    logic [c_sw-1:0]      r_out [NCH];

    logic [LPF_TAP_W-1:0] w_coef;
    logic [c_sw-1:0]      w_smp_sel;
    logic [c_pw-1:0]      w_prod;

    lpf_tap_rom u_rom (
        .i_tap  (r_tap),
        .o_coef (w_coef)
    );

    always_comb begin
        w_smp_sel = '0;
        for (int c = 0; c < NCH; c++) begin
            if (r_ch == c_cw'(c)) begin
                w_smp_sel = r_smp[c];
            end
        end
        w_prod = c_pw'(w_coef) * c_pw'(w_smp_sel);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= c_st_idle;
            r_tap    <= '0;
            r_ch     <= '0;
            r_ovalid <= 1'b0;
        end else begin
            r_ovalid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.CE) begin
                        if (r_tap == c_last_tap) begin
                            r_state <= c_st_wrap;
                        end else begin
                            r_ch    <= '0;
                            r_state <= c_st_mac;
                        end
                    end
                end
                c_st_mac: begin
                    if (r_ch == c_last_ch) begin
                        r_tap   <= r_tap + 7'd1;
                        r_state <= c_st_idle;
                    end else begin
                        r_ch <= r_ch + c_cw'(1);
                    end
                end
                c_st_wrap: begin
                    r_tap    <= '0;
                    r_ovalid <= 1'b1;
                    r_state  <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Last ROM entry is never multiplied: the wrap cycle dumps taps 0..70.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int c = 0; c < NCH; c++) begin
                r_smp[c] <= '0;
                r_acc[c] <= '0;
                r_out[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (r_state == c_st_idle && bus.CE) begin
                    r_smp[c] <= bus.IDATA[c*c_sw +: c_sw];
                end
                if (r_state == c_st_mac && r_ch == c_cw'(c)) begin
                    r_acc[c] <= r_acc[c] + c_aw'(w_prod);
                end else if (r_state == c_st_wrap) begin
                    r_out[c] <= r_acc[c][MSB+10:10];
                    r_acc[c] <= '0;
                end
            end
        end
    end

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_lane
            assign bus.ODATA[c*c_sw +: c_sw] = bus.ENABLE ? r_out[c]
                                                          : bus.IDATA[c*c_sw +: c_sw];
        end
    endgenerate

    assign bus.BUSY   = (r_state != c_st_idle);
    assign bus.OVALID = r_ovalid;

`ifdef LPF_SCHED_OVR_EN
    logic w_drop;
    logic r_ovr;

    assign w_drop = bus.CE && (r_state != c_st_idle);

    // A new overrun outranks a simultaneous clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ovr <= 1'b0;
        end else if (w_drop) begin
            r_ovr <= 1'b1;
        end else if (bus.OVR_CLR) begin
            r_ovr <= 1'b0;
        end
    end

    assign bus.OVR = r_ovr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lpf_mac_sched.sv
// ============================================================================
// Module      : tb_lpf_mac_sched
// Description : Directed self-checking bench for lpf_mac_sched (NCH=2 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lpf_mac_sched;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    lpf_mac_sched_if #(.MSB(15), .NCH(2)) if2 ();
    lpf_mac_sched_if #(.MSB(15), .NCH(1)) if1 ();

    lpf_mac_sched #(.MSB(15), .NCH(2)) u_dut2 (.CLK(CLK), .RESET(RESET), .bus(if2));
    lpf_mac_sched #(.MSB(15), .NCH(1)) u_dut1 (.CLK(CLK), .RESET(RESET), .bus(if1));

    int          errors = 0;
    int          checks = 0;
    int          ov_cnt;
    logic [31:0] cap2;
    logic [15:0] cap1;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample(input int sel);
        if (sel == 2 && if2.OVALID === 1'b1) begin
            ov_cnt++;
            cap2 = if2.ODATA;
        end
        if (sel == 1 && if1.OVALID === 1'b1) begin
            ov_cnt++;
            cap1 = if1.ODATA;
        end
    endtask

    task automatic run_ticks(input int sel, input int n, input int spacing);
        for (int i = 0; i < n; i++) begin
            if (sel == 2) if2.CE = 1'b1;
            else          if1.CE = 1'b1;
            tick();
            if2.CE = 1'b0;
            if1.CE = 1'b0;
            sample(sel);
            for (int g = 1; g < spacing; g++) begin
                tick();
                sample(sel);
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        checks++; if (if2.ODATA !== 32'd0) begin errors++; $display("FAIL reset_odata: got %h expected 0", if2.ODATA); end
        checks++; if (if2.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", if2.BUSY); end
        checks++; if (if2.OVALID !== 1'b0) begin errors++; $display("FAIL reset_ovalid: got %b expected 0", if2.OVALID); end
        checks++; if (if1.ODATA !== 16'd0) begin errors++; $display("FAIL reset_odata1: got %h expected 0", if1.ODATA); end
`ifdef LPF_SCHED_OVR_EN
        checks++; if (if2.OVR !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", if2.OVR); end
`endif
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_dc_both();
        if2.IDATA = {16'd1000, 16'd1000};
        ov_cnt = 0;
        run_ticks(2, 71, 4);
        checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL dc_early_ovalid: got %0d expected 0", ov_cnt); end
        run_ticks(2, 1, 4);
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL dc_ovalid_cnt: got %0d expected 1", ov_cnt); end
        checks++; if (cap2 !== {16'd862, 16'd862}) begin errors++; $display("FAIL dc_value: got %h expected %h", cap2, {16'd862, 16'd862}); end
        checks++; if (if2.ODATA !== {16'd862, 16'd862}) begin errors++; $display("FAIL dc_hold: got %h expected %h", if2.ODATA, {16'd862, 16'd862}); end
    endtask

    task automatic test_step_busy();
        if2.IDATA = {16'd0, 16'hFFFF};
        ov_cnt = 0;
        if2.CE = 1'b1;
        tick();
        if2.CE = 1'b0;
        checks++; if (if2.BUSY !== 1'b1) begin errors++; $display("FAIL busy_c1: got %b expected 1", if2.BUSY); end
        tick();
        checks++; if (if2.BUSY !== 1'b1) begin errors++; $display("FAIL busy_c2: got %b expected 1", if2.BUSY); end
        tick();
        checks++; if (if2.BUSY !== 1'b0) begin errors++; $display("FAIL busy_c3: got %b expected 0", if2.BUSY); end
        // Next CE lands exactly NCH+1 clocks after the previous one.
        run_ticks(2, 71, 3);
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL step_ovalid_cnt: got %0d expected 1", ov_cnt); end
        checks++; if (cap2 !== {16'd0, 16'd56511}) begin errors++; $display("FAIL step_value: got %h expected %h", cap2, {16'd0, 16'd56511}); end
    endtask

    task automatic test_back_to_back();
        if2.IDATA = {16'd1000, 16'd1000};
        ov_cnt = 0;
        if2.CE = 1'b1;
        tick();
`ifdef LPF_SCHED_OVR_EN
        if2.OVR_CLR = 1'b1;
`endif
        tick();
        if2.CE = 1'b0;
`ifdef LPF_SCHED_OVR_EN
        if2.OVR_CLR = 1'b0;
        checks++; if (if2.OVR !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b expected 1", if2.OVR); end
`endif
        tick();
        tick();
`ifdef LPF_SCHED_OVR_EN
        checks++; if (if2.OVR !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", if2.OVR); end
        if2.OVR_CLR = 1'b1;
        tick();
        if2.OVR_CLR = 1'b0;
        checks++; if (if2.OVR !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", if2.OVR); end
`endif
        run_ticks(2, 70, 4);
        checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL b2b_early_ovalid: got %0d expected 0", ov_cnt); end
        run_ticks(2, 1, 4);
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL b2b_ovalid_cnt: got %0d expected 1", ov_cnt); end
        checks++; if (cap2 !== {16'd862, 16'd862}) begin errors++; $display("FAIL b2b_value: got %h expected %h", cap2, {16'd862, 16'd862}); end
    endtask

    task automatic test_reset_mid();
        if2.IDATA = {16'hFFFF, 16'hFFFF};
        run_ticks(2, 30, 4);
        if2.CE = 1'b1;
        tick();
        if2.CE = 1'b0;
        checks++; if (if2.BUSY !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", if2.BUSY); end
        RESET = 1'b1;
        #2;
        checks++; if (if2.ODATA !== 32'd0) begin errors++; $display("FAIL mid_rst_odata: got %h expected 0", if2.ODATA); end
        checks++; if (if2.BUSY !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", if2.BUSY); end
        checks++; if (if2.OVALID !== 1'b0) begin errors++; $display("FAIL mid_rst_ovalid: got %b expected 0", if2.OVALID); end
        RESET = 1'b0;
        tick();
        if2.IDATA = {16'd1000, 16'd1000};
        ov_cnt = 0;
        run_ticks(2, 71, 4);
        checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL mid_early_ovalid: got %0d expected 0", ov_cnt); end
        run_ticks(2, 1, 4);
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL mid_ovalid_cnt: got %0d expected 1", ov_cnt); end
        checks++; if (cap2 !== {16'd862, 16'd862}) begin errors++; $display("FAIL mid_value: got %h expected %h", cap2, {16'd862, 16'd862}); end
    endtask

    task automatic test_passthru();
        if2.ENABLE = 1'b0;
        if2.IDATA  = {16'hABCD, 16'h1234};
        #1;
        checks++; if (if2.ODATA !== 32'hABCD1234) begin errors++; $display("FAIL pass_a: got %h expected abcd1234", if2.ODATA); end
        if2.IDATA = 32'h5555AAAA;
        #1;
        checks++; if (if2.ODATA !== 32'h5555AAAA) begin errors++; $display("FAIL pass_b: got %h expected 5555aaaa", if2.ODATA); end
        if2.IDATA = {16'hABCD, 16'h1234};
        tick();
        ov_cnt = 0;
        run_ticks(2, 72, 4);
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL pass_ovalid_cnt: got %0d expected 1", ov_cnt); end
        if2.ENABLE = 1'b1;
        #1;
        checks++; if (if2.ODATA !== {16'd37925, 16'd4018}) begin errors++; $display("FAIL pass_filtered: got %h expected %h", if2.ODATA, {16'd37925, 16'd4018}); end
    endtask

    task automatic test_single_ch();
        if1.ENABLE = 1'b1;
        if1.IDATA  = 16'd500;
        ov_cnt = 0;
        if1.CE = 1'b1;
        tick();
        if1.CE = 1'b0;
        checks++; if (if1.BUSY !== 1'b1) begin errors++; $display("FAIL single_busy1: got %b expected 1", if1.BUSY); end
        tick();
        checks++; if (if1.BUSY !== 1'b0) begin errors++; $display("FAIL single_busy2: got %b expected 0", if1.BUSY); end
        run_ticks(1, 71, 2);
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL single_ovalid_cnt: got %0d expected 1", ov_cnt); end
        checks++; if (cap1 !== 16'd431) begin errors++; $display("FAIL single_value: got %0d expected 431", cap1); end
`ifdef LPF_SCHED_OVR_EN
        checks++; if (if1.OVR !== 1'b0) begin errors++; $display("FAIL single_ovr: got %b expected 0", if1.OVR); end
`endif
    endtask

    initial begin
        RESET      = 1'b1;
        if2.CE     = 1'b0;
        if2.ENABLE = 1'b1;
        if2.IDATA  = '0;
        if1.CE     = 1'b0;
        if1.ENABLE = 1'b1;
        if1.IDATA  = '0;
`ifdef LPF_SCHED_OVR_EN
        if2.OVR_CLR = 1'b0;
        if1.OVR_CLR = 1'b0;
`endif
        cap2   = '0;
        cap1   = '0;
        ov_cnt = 0;

        test_reset();
        test_dc_both();
        test_step_busy();
        test_back_to_back();
        test_reset_mid();
        test_passthru();
        test_single_ch();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
